// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stage indices, stall/flush vector constants and FSM encodings
// for the pipeline stall/flush controller.
package pipe_stall_ctrl_pkg;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

    // The bubble always goes into the register just past the highest held one.
    function automatic logic [4:0] bubble_after(input logic [4:0] stall_vec);
        return (stall_vec << 1) & ~stall_vec;
    endfunction

    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_LU   = 5'b00011;
    localparam logic [4:0] STALL_DIV  = 5'b00111;
    localparam logic [4:0] STALL_MEM  = 5'b01111;

    localparam logic [4:0] FLUSH_NONE = 5'b00000;
    localparam logic [4:0] FLUSH_LU   = bubble_after(STALL_LU);
    localparam logic [4:0] FLUSH_DIV  = bubble_after(STALL_DIV);
    localparam logic [4:0] FLUSH_MEM  = bubble_after(STALL_MEM);
    localparam logic [4:0] FLUSH_EXC  = 5'b11110;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_stall_ctrl_perf_counter.sv
// Saturating cycle counter with enable and synchronous clear.
module stall_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, divide wait,
// data-memory wait and EX exceptions.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_RUN      | pipeline flowing; single-cycle hazards resolved here
//   ST_MEM_WAIT | waiting for mem_ack; EX exceptions deferred in pend_exc
//   ST_DIV_WAIT | waiting for div_ready; timer counts toward abort
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_id_load_use,
    input  logic             i_ex_div_start,
    input  logic             i_div_ready,
    input  logic             i_mem_req,
    input  logic             i_mem_ack,
    input  logic             i_ex_exception,
    output logic [4:0]       o_stall,
    output logic [4:0]       o_flush,
    output logic             o_div_busy,
    output logic             o_div_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int              TMR_W    = $clog2(DIV_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DIV_TIMEOUT - 1);

    state_t            r_state;
    logic [TMR_W-1:0]  r_timer;
    logic              r_pend_exc;
    logic              r_div_err;

    state_t            w_state_nxt;
    logic [TMR_W-1:0]  w_timer_nxt;
    logic              w_pend_nxt;
    logic              w_div_err_nxt;

    logic              w_mem_stall;
    logic              w_div_stall;
    logic              w_timeout;

    assign w_mem_stall = i_mem_req & ~i_mem_ack;
    assign w_div_stall = i_ex_div_start & ~i_div_ready;
    assign w_timeout   = (r_timer == TMR_LAST) & ~i_div_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_timer    <= '0;
            r_pend_exc <= 1'b0;
            r_div_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_pend_exc <= w_pend_nxt;
            r_div_err  <= w_div_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_pend_nxt    = r_pend_exc;
        w_div_err_nxt = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_timer_nxt = '0;
                w_pend_nxt  = 1'b0;
                if (!i_ex_exception) begin
                    if (w_mem_stall) begin
                        w_state_nxt = ST_MEM_WAIT;
                    end else if (w_div_stall) begin
                        w_state_nxt = ST_DIV_WAIT;
                        w_timer_nxt = TMR_W'(1);
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (i_mem_ack) begin
                    w_state_nxt = ST_RUN;
                    w_pend_nxt  = 1'b0;
                end else if (i_ex_exception) begin
                    w_pend_nxt  = 1'b1;
                end
            end
            ST_DIV_WAIT: begin
                // A memory stall freezes the pipe, so the timer holds too.
                if (i_ex_exception || i_div_ready) begin
                    w_state_nxt = ST_RUN;
                    w_timer_nxt = '0;
                end else if (w_mem_stall) begin
                    w_timer_nxt = r_timer;
                end else if (w_timeout) begin
                    w_state_nxt   = ST_RUN;
                    w_timer_nxt   = '0;
                    w_div_err_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_timer_nxt = '0;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_stall = STALL_NONE;
        o_flush = FLUSH_NONE;
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (i_ex_exception) begin
                        o_flush = FLUSH_EXC;
                    end else if (w_mem_stall) begin
                        o_stall = STALL_MEM;
                        o_flush = FLUSH_MEM;
                    end else if (w_div_stall) begin
                        o_stall = STALL_DIV;
                        o_flush = FLUSH_DIV;
                    end else if (i_id_load_use) begin
                        o_stall = STALL_LU;
                        o_flush = FLUSH_LU;
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_mem_ack) begin
                        if (r_pend_exc || i_ex_exception) begin
                            o_flush = FLUSH_EXC;
                        end
                    end else begin
                        o_stall = STALL_MEM;
                        o_flush = FLUSH_MEM;
                    end
                end
                ST_DIV_WAIT: begin
                    if (i_ex_exception) begin
                        o_flush = FLUSH_EXC;
                    end else if (w_mem_stall) begin
                        o_stall = STALL_MEM;
                        o_flush = FLUSH_MEM;
                    end else if (i_div_ready) begin
                        o_stall = STALL_NONE;
                    end else if (w_timeout) begin
                        o_flush = FLUSH_EXC;
                    end else begin
                        o_stall = STALL_DIV;
                        o_flush = FLUSH_DIV;
                    end
                end
                default: begin
                    o_stall = STALL_NONE;
                end
            endcase
        end
    end

    assign o_div_busy = (r_state == ST_DIV_WAIT);
    assign o_div_err  = r_div_err;

    stall_perf_counter #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk   (clk),
        .i_clr (rst),
        .i_en  (o_stall[STG_PC]),
        .o_cnt (o_stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: default-timeout instance plus a
// DIV_TIMEOUT=8 instance driven from the same inputs.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, lu, dstart, dready, mreq, mack, exc;

    logic [4:0]  a_stall, a_flush, b_stall, b_flush;
    logic        a_busy, a_err, b_busy, b_err;
    logic [31:0] a_cnt, b_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cycles;

    pipe_stall_ctrl #(.DIV_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_id_load_use(lu), .i_ex_div_start(dstart), .i_div_ready(dready),
        .i_mem_req(mreq), .i_mem_ack(mack), .i_ex_exception(exc),
        .o_stall(a_stall), .o_flush(a_flush), .o_div_busy(a_busy),
        .o_div_err(a_err), .o_stall_cnt(a_cnt)
    );

    pipe_stall_ctrl #(.DIV_TIMEOUT(8), .CNT_W(32)) dut8 (
        .clk(clk), .rst(rst),
        .i_id_load_use(lu), .i_ex_div_start(dstart), .i_div_ready(dready),
        .i_mem_req(mreq), .i_mem_ack(mack), .i_ex_exception(exc),
        .o_stall(b_stall), .o_flush(b_flush), .o_div_busy(b_busy),
        .o_div_err(b_err), .o_stall_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic l, input logic s, input logic r,
                         input logic q, input logic a, input logic e);
        @(negedge clk);
        lu = l; dstart = s; dready = r; mreq = q; mack = a; exc = e;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        lu = 0; dstart = 0; dready = 0; mreq = 0; mack = 0; exc = 0;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        lu = 0; dstart = 0; dready = 0; mreq = 0; mack = 0; exc = 0;

        // reset state
        do_reset();
        drive(0,0,0,0,0,0);
        chk("rst_cnt",   a_cnt, 32'd0);
        chk("rst_err",   32'(a_err), 32'd0);
        chk("rst_busy",  32'(a_busy), 32'd0);
        chk("rst_stall", 32'(a_stall), 32'd0);

        // load-use: one bubble
        drive(1,0,0,0,0,0);
        chk("lu_stall", 32'(a_stall), 32'b00011);
        chk("lu_flush", 32'(a_flush), 32'b00100);
        drive(0,0,0,0,0,0);
        chk("lu_stall_rel", 32'(a_stall), 32'd0);
        chk("lu_flush_rel", 32'(a_flush), 32'd0);
        chk("lu_cnt", a_cnt, 32'd1);

        // memory wait 3 cycles, released in the ack cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0,0,0,1,0,0);
            chk("mem_stall", 32'(a_stall), 32'b01111);
            chk("mem_flush", 32'(a_flush), 32'b10000);
        end
        drive(0,0,0,1,1,0);
        chk("mem_ack_stall", 32'(a_stall), 32'd0);
        chk("mem_ack_flush", 32'(a_flush), 32'd0);
        drive(0,0,0,0,0,0);
        chk("mem_cnt", a_cnt, 32'd3);
        drive(0,0,0,1,1,0);
        chk("mem_zero_lat", 32'(a_stall), 32'd0);
        drive(0,1,1,0,0,0);
        chk("div_zero_lat", 32'(a_stall), 32'd0);

        // divide, ready arrives on the 10th busy cycle
        do_reset();
        busy_cycles = 0;
        drive(0,1,0,0,0,0);
        chk("div_entry_stall", 32'(a_stall), 32'b00111);
        chk("div_entry_flush", 32'(a_flush), 32'b01000);
        chk("div_entry_busy", 32'(a_busy), 32'd0);
        for (int i = 0; i < 9; i++) begin
            drive(0,1,0,0,0,0);
            if (a_busy) busy_cycles++;
            chk("div_wait_stall", 32'(a_stall), 32'b00111);
        end
        drive(0,1,1,0,0,0);
        if (a_busy) busy_cycles++;
        chk("div_ready_stall", 32'(a_stall), 32'd0);
        drive(0,0,0,0,0,0);
        chk("div_busy_cycles", 32'(busy_cycles), 32'd10);
        chk("div_busy_off", 32'(a_busy), 32'd0);
        chk("div_no_err", 32'(a_err), 32'd0);
        chk("div_cnt", a_cnt, 32'd10);

        // divide timeout on the DIV_TIMEOUT=8 instance
        do_reset();
        drive(0,1,0,0,0,0);
        chk("to_entry_stall", 32'(b_stall), 32'b00111);
        for (int i = 0; i < 6; i++) begin
            drive(0,1,0,0,0,0);
            chk("to_wait_stall", 32'(b_stall), 32'b00111);
            chk("to_wait_err", 32'(b_err), 32'd0);
        end
        drive(0,0,0,0,0,0);
        chk("to_flush", 32'(b_flush), 32'b11110);
        chk("to_stall", 32'(b_stall), 32'd0);
        drive(0,0,0,0,0,0);
        chk("to_err_pulse", 32'(b_err), 32'd1);
        chk("to_busy_off", 32'(b_busy), 32'd0);
        chk("to_flush_once", 32'(b_flush), 32'd0);
        drive(0,0,0,0,0,0);
        chk("to_err_clear", 32'(b_err), 32'd0);

        // exception deferred during memory wait
        do_reset();
        drive(0,0,0,1,0,0);
        chk("mx_c1_flush", 32'(a_flush), 32'b10000);
        drive(0,0,0,1,0,1);
        chk("mx_exc_stall", 32'(a_stall), 32'b01111);
        chk("mx_exc_flush", 32'(a_flush), 32'b10000);
        drive(0,0,0,1,0,0);
        chk("mx_c3_flush", 32'(a_flush), 32'b10000);
        drive(0,0,0,1,1,0);
        chk("mx_ack_flush", 32'(a_flush), 32'b11110);
        chk("mx_ack_stall", 32'(a_stall), 32'd0);
        drive(0,0,0,0,0,0);
        chk("mx_pend_clr", 32'(a_flush), 32'd0);

        // simultaneous hazards, memory stall inside divide, abort and reset
        do_reset();
        drive(1,1,0,1,0,0);
        chk("all_stall", 32'(a_stall), 32'b01111);
        chk("all_flush", 32'(a_flush), 32'b10000);
        drive(0,1,0,0,1,0);
        chk("all_ack_stall", 32'(a_stall), 32'd0);
        drive(0,1,0,0,0,0);
        chk("dm_entry", 32'(a_stall), 32'b00111);
        drive(0,1,0,0,0,0);
        chk("dm_busy", 32'(a_busy), 32'd1);
        drive(0,1,0,1,0,0);
        chk("dm_mem_stall", 32'(a_stall), 32'b01111);
        chk("dm_mem_flush", 32'(a_flush), 32'b10000);
        drive(0,1,0,0,0,0);
        chk("dm_back_div", 32'(a_stall), 32'b00111);
        chk("dm_still_busy", 32'(a_busy), 32'd1);
        drive(0,1,0,0,0,1);
        chk("dx_flush", 32'(a_flush), 32'b11110);
        chk("dx_stall", 32'(a_stall), 32'd0);
        drive(0,0,0,0,0,0);
        chk("dx_busy_off", 32'(a_busy), 32'd0);

        drive(0,1,0,0,0,0);
        drive(0,1,0,0,0,0);
        chk("rd_busy", 32'(a_busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rd_rst_stall", 32'(a_stall), 32'd0);
        chk("rd_rst_flush", 32'(a_flush), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dstart = 1'b0;
        #1;
        chk("rd_run_busy", 32'(a_busy), 32'd0);
        chk("rd_run_stall", 32'(a_stall), 32'd0);
        drive(0,0,1,0,0,0);
        chk("rd_ready_ign", 32'(a_stall), 32'd0);
        drive(0,0,0,0,1,0);
        chk("rd_ack_ign", 32'(a_flush), 32'd0);
        chk("rd_cnt", a_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB registers). It sequences the pipeline registers through four hazard sources:
- load-use hazards;
- multi-cycle divide in EX;
- data-memory wait states in MEM;
- exceptions raised in EX.
Each pipeline register consumes one stall bit (hold) and one flush bit (load bubble/zero), indexed 0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB.

Parameters:
DIV_TIMEOUT, 64, max cycles in DIV_WAIT before abort with div_err.
CNT_W, 32, width of the stall performance counter.

Ports:
clk  in  1  clock
rst  in  1  reset; rst is synchronous, active-high; clock clk
id_load_use  in  1  ID detected load-use hazard with the instruction in EX
ex_div_start  in  1  EX holds a divide; pulse/level while the divide is waiting
div_ready  in  1  divider result valid this cycle
mem_req  in  1  MEM stage issuing a data-memory access
mem_ack  in  1  data memory completes the access this cycle
ex_exception  in  1  EX raised an exception (level, one cycle)
stall  out  5  per-register hold enables
flush  out  5  per-register bubble enables
div_busy  out  1  high while in DIV_WAIT
div_err  out  1  one-cycle pulse on divide timeout
stall_cnt  out  CNT_W  saturating count of cycles with stall[0]=1

Behaviour:
- stall and flush are combinational from the registered state and the current inputs. state, timer, pend_exc, div_err and stall_cnt are registered.
- Reset: state=RUN, timer=0, pend_exc=0, div_err=0, stall_cnt=0. While rst=1, stall=0 and flush=0.
- FSM states: RUN, MEM_WAIT, DIV_WAIT.
- RUN priority, highest first:
  1. ex_exception: flush=5'b11110, stall=0, stay in RUN.
  2. mem_req && !mem_ack: stall=5'b01111, flush=5'b10000, next state MEM_WAIT.
  3. ex_div_start && !div_ready: stall=5'b00111, flush=5'b01000, next state DIV_WAIT, timer=1.
  4. id_load_use: stall=5'b00011, flush=5'b00100, one bubble only, stay in RUN.
  5. Otherwise: stall=0, flush=0.
- Zero-latency cases: mem_req with mem_ack set in the same cycle causes no stall. A divide with div_ready set in the same cycle causes no stall.
- MEM_WAIT:
  - While !mem_ack: stall=5'b01111, flush=5'b10000.
  - On mem_ack: stall=0, flush=0, next state RUN. If pend_exc=1, instead flush=5'b11110, then clear pend_exc.
  - ex_exception arriving during MEM_WAIT sets pend_exc and is not acted on until mem_ack.
  - Only one outstanding memory access is allowed.
- DIV_WAIT:
  - div_busy=1.
  - While !div_ready: stall=5'b00111, flush=5'b01000, timer increments each cycle.
  - On div_ready: stall=0, flush=0, next state RUN, timer=0.
  - Timeout: when timer==DIV_TIMEOUT-1 and !div_ready, pulse div_err next cycle, flush=5'b11110, next state RUN.
  - ex_exception in DIV_WAIT aborts the divide: flush=5'b11110, next state RUN, timer=0.
  - A memory stall outranks the divide. If mem_req && !mem_ack occurs in DIV_WAIT, apply the MEM_WAIT vector (stall=5'b01111, flush=5'b10000) that cycle, stay in DIV_WAIT, and freeze the timer.
- Invariant: stall[k]=1 implies stall[j]=1 for all j<k. The flush bit is set only on the register immediately after the highest stalled one, or on exception.
- stall_cnt increments each cycle stall[0]=1 and saturates at all-ones.
- Reset mid-operation: at the next clk, state returns to RUN and pend_exc and timer are cleared. Any later mem_ack or div_ready is ignored while in RUN without a request.

Decomposition:
- Shared defines/package: stage index constants (STG_PC..STG_MEMWB), the 5-bit stall/flush vector constants (STALL_NONE, STALL_LU, STALL_DIV, STALL_MEM, FLUSH_EXC) and the FSM state encodings.
- One sub-module, stall_perf_counter: a saturating CNT_W counter with enable and synchronous clear.

Test Plan:
1. Load-use: id_load_use=1 for 1 cycle in RUN -> stall=5'b00011, flush=5'b00100 for exactly 1 cycle, then 0. stall_cnt=1.
2. Memory wait: mem_req=1 with mem_ack low for 3 cycles -> stall=5'b01111 and flush=5'b10000 for 3 cycles, released in the ack cycle. stall_cnt=3.
3. Divide: ex_div_start, then div_ready after 10 cycles -> div_busy high for 10 cycles, stall=5'b00111, back to RUN, no div_err.
4. Divide timeout with DIV_TIMEOUT=8 and div_ready never asserted -> div_err pulses once, flush=5'b11110 once, state RUN.
5. Exception during MEM_WAIT: ex_exception at cycle 2 of the wait, mem_ack at cycle 4 -> no flush until the ack cycle, flush=5'b11110 in the ack cycle, pend_exc cleared.
6. Simultaneous id_load_use, ex_div_start and mem_req (no ack) -> MEM vector wins. rst asserted mid-DIV_WAIT -> stall=0 and flush=0 during reset, then RUN.
